ldpc_core_model: RTL

- Parametrised behavioural LDPC core stand-in for system-level benches and integration before the real decoder lands.
- Latches a codeword of LLRs on start and runs a cycle-accurate iteration schedule with a runtime maximum-iteration count.
- Supports optional early termination driven by an external syndrome checker.
- Produces real hard decisions (LLR sign bits) and reports converged/failed status and the iteration count.

---
 rtl/ldpc_pkg.sv | 14 +
 rtl/ldpc_core_model_if.sv | 32 +++
 rtl/ldpc_hard_dec.sv | 20 ++
 rtl/ldpc_core_model.sv | 121 ++++++++++++
 4 files changed

// File: rtl/ldpc_pkg.sv
// Shared types and default geometry for the behavioural LDPC core stand-in.
// Pure declarations: no latency, no flow control.
package ldpc_pkg;

  typedef enum logic [1:0] {IDLE, ITER, CHECK, DONE} state_t;

  localparam int DEF_DATA_W = 5;
  localparam int DEF_MTX_W  = 8;
  localparam int DEF_R      = 24;
  localparam int DEF_C      = 12;
  localparam int DEF_D      = 96;
  localparam int N_BITS     = DEF_R * DEF_D;

endpackage

// File: rtl/ldpc_core_model_if.sv
// Decode request/result bundle between a bench or system model and the LDPC core.
// Level/pulse signalling only: start is a request, term is the completion pulse.
interface ldpc_core_model_if #(
  parameter int DATA_W = ldpc_pkg::DEF_DATA_W,
  parameter int MTX_W  = ldpc_pkg::DEF_MTX_W,
  parameter int R      = ldpc_pkg::DEF_R,
  parameter int C      = ldpc_pkg::DEF_C,
  parameter int D      = ldpc_pkg::DEF_D,
  parameter int ITER_W = 4
);
  logic                       start;
  logic [ITER_W-1:0]          max_iter;
  logic                       early_en;
  logic                       synd_ok;
  logic [R*D*DATA_W-1:0]      sig;
  logic [C*R*MTX_W-1:0]       mtx;
  logic                       busy;
  logic                       term;
  logic                       converged;
  logic [ITER_W-1:0]          iter_cnt;
  logic [R*D-1:0]             res;

  modport master (
    output start, max_iter, early_en, synd_ok, sig, mtx,
    input  busy, term, converged, iter_cnt, res
  );

  modport slave (
    input  start, max_iter, early_en, synd_ok, sig, mtx,
    output busy, term, converged, iter_cnt, res
  );
endinterface

// File: rtl/ldpc_hard_dec.sv
// Combinational sign slicer: one hard bit per LLR, 1 for a negative LLR.
// Zero latency, no flow control; the parent registers the result.
module ldpc_hard_dec #(
  parameter int DATA_W = ldpc_pkg::DEF_DATA_W,
  parameter int N_BITS = ldpc_pkg::N_BITS
) (
  input  logic [N_BITS*DATA_W-1:0] llr,
  output logic [N_BITS-1:0]        hard
);
  // Magnitude bits carry no information for a hard decision.
  logic unused_llr;
  assign unused_llr = ^llr;

  always_comb begin
    hard = '0;
    for (int i = 0; i < N_BITS; i++) begin
      hard[i] = llr[i*DATA_W + DATA_W - 1];
    end
  end
endmodule

// File: rtl/ldpc_core_model.sv
// Behavioural LDPC core: N*(CYC_PER_ITER+1) cycles from start to the DONE/term cycle.
// start is ignored while busy (including DONE); no stall path, synd_ok is sampled in CHECK only.
module ldpc_core_model
  import ldpc_pkg::*;
#(
  parameter int DATA_W       = DEF_DATA_W,
  parameter int MTX_W        = DEF_MTX_W,
  parameter int R            = DEF_R,
  parameter int C            = DEF_C,
  parameter int D            = DEF_D,
  parameter int ITER_W       = 4,
  parameter int CYC_PER_ITER = 8
) (
  input logic              clk,
  input logic              rst,
  ldpc_core_model_if.slave bus
);
  localparam int NB   = R * D;
  localparam int PH_W = $clog2(CYC_PER_ITER);

  state_t                state, state_d;
  logic [PH_W-1:0]       phase, phase_d;
  logic [ITER_W-1:0]     iter_cnt, iter_d, max_iter_q;
  logic                  early_en_q;
  logic                  conv_q, conv_d;
  logic                  busy_q, term_q;
  logic [NB*DATA_W-1:0]  sig_q;
  logic [C*R*MTX_W-1:0]  mtx_q;
  logic [NB-1:0]         hard, res_q;
  logic                  accept;

  // The matrix is captured for interface fidelity; this model never decodes with it.
  logic unused_mtx;
  assign unused_mtx = ^mtx_q;

  assign accept = (state == IDLE) && bus.start;

  always_comb begin
    state_d = state;
    phase_d = phase;
    iter_d  = iter_cnt;
    conv_d  = conv_q;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          phase_d = '0;
          iter_d  = '0;
          // A zero limit still passes through one CHECK so DONE lands one edge later.
          state_d = (bus.max_iter == '0) ? CHECK : ITER;
        end
      end
      ITER: begin
        if (phase == PH_W'(CYC_PER_ITER - 1)) begin
          phase_d = '0;
          iter_d  = iter_cnt + 1'b1;
          state_d = CHECK;
        end else begin
          phase_d = phase + 1'b1;
        end
      end
      CHECK: begin
        if (early_en_q && bus.synd_ok && (iter_cnt != '0)) begin
          conv_d  = 1'b1;
          state_d = DONE;
        end else if (iter_cnt == max_iter_q) begin
          conv_d  = 1'b0;
          state_d = DONE;
        end else begin
          state_d = ITER;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      phase    <= '0;
      iter_cnt <= '0;
      conv_q   <= 1'b0;
      busy_q   <= 1'b0;
      term_q   <= 1'b0;
      res_q    <= '0;
    end else begin
      state    <= state_d;
      phase    <= phase_d;
      iter_cnt <= iter_d;
      conv_q   <= conv_d;
      busy_q   <= (state_d != IDLE);
      term_q   <= (state_d == DONE);
      if (state_d == DONE) begin
        res_q <= hard;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      sig_q      <= bus.sig;
      mtx_q      <= bus.mtx;
      max_iter_q <= bus.max_iter;
      early_en_q <= bus.early_en;
    end
  end

  ldpc_hard_dec #(
    .DATA_W (DATA_W),
    .N_BITS (NB)
  ) u_hard_dec (
    .llr  (sig_q),
    .hard (hard)
  );

  assign bus.busy      = busy_q;
  assign bus.term      = term_q;
  assign bus.converged = conv_q;
  assign bus.iter_cnt  = iter_cnt;
  assign bus.res       = res_q;
endmodule
